// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, and registered
// sync / blanking / coordinate outputs decoded from the counters as they update.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          h_sync,
   output logic          v_sync,
   output logic          video_on,
   output logic [CW-1:0] x_loc,
   output logic [CW-1:0] y_loc,
   output logic          pix_tick,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST = H_ACTIVE + H_FP;
   localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int VS_FIRST = V_ACTIVE + V_FP;
   localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
   localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

   generate
      if (CLK_DIV < 1) begin : g_clk_div_err
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
      if ((H_TOTAL - 1) > ((2 ** CW) - 1)) begin : g_h_width_err
         $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
      end
      if ((V_TOTAL - 1) > ((2 ** CW) - 1)) begin : g_v_width_err
         $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
      end
   endgenerate

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_count_q, h_count_d;
   logic [CW-1:0] v_count_q, v_count_d;
   logic          first_q, first_d;
   logic          h_sync_q, h_sync_d;
   logic          v_sync_q, v_sync_d;
   logic          video_on_q, video_on_d;
   logic [CW-1:0] x_loc_q, x_loc_d;
   logic [CW-1:0] y_loc_q, y_loc_d;
   logic          pix_tick_q, pix_tick_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   logic          tick;
   logic          h_wrap;
   logic          v_wrap;
   logic          h_vis;
   logic          v_vis;

   assign tick   = enable && (div_q == DIV_LAST);
   assign h_wrap = (h_count_q == H_LAST);
   assign v_wrap = (v_count_q == V_LAST);

   // The first tick after reset presents (0,0) itself instead of advancing, so
   // the raster starts at the origin and the first frame_start comes at the wrap.
   always_comb begin
      div_d         = div_q;
      h_count_d     = h_count_q;
      v_count_d     = v_count_q;
      first_d       = first_q;
      pix_tick_d    = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (enable) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (tick) begin
         pix_tick_d = 1'b1;
         if (first_q) begin
            first_d = 1'b0;
         end else begin
            h_count_d = h_wrap ? '0 : h_count_q + CW'(1);
            if (h_wrap) begin
               v_count_d = v_wrap ? '0 : v_count_q + CW'(1);
            end
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
         end
      end
   end

   assign h_vis = (h_count_d < CW'(H_ACTIVE));
   assign v_vis = (v_count_d < CW'(V_ACTIVE));

   // Level outputs only change on a tick, decoded from the counters being loaded.
   always_comb begin
      h_sync_d   = h_sync_q;
      v_sync_d   = v_sync_q;
      video_on_d = video_on_q;
      x_loc_d    = x_loc_q;
      y_loc_d    = y_loc_q;
      if (tick) begin
         h_sync_d   = ((h_count_d >= CW'(HS_FIRST)) && (h_count_d <= CW'(HS_LAST)))
                      ? HS_POL : ~HS_POL;
         v_sync_d   = ((v_count_d >= CW'(VS_FIRST)) && (v_count_d <= CW'(VS_LAST)))
                      ? VS_POL : ~VS_POL;
         video_on_d = h_vis && v_vis;
         x_loc_d    = (h_vis && v_vis) ? h_count_d : '0;
         y_loc_d    = (h_vis && v_vis) ? v_count_d : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         h_count_q     <= '0;
         v_count_q     <= '0;
         first_q       <= 1'b1;
         h_sync_q      <= ~HS_POL;
         v_sync_q      <= ~VS_POL;
         video_on_q    <= 1'b0;
         x_loc_q       <= '0;
         y_loc_q       <= '0;
         pix_tick_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_count_q     <= h_count_d;
         v_count_q     <= v_count_d;
         first_q       <= first_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         video_on_q    <= video_on_d;
         x_loc_q       <= x_loc_d;
         y_loc_q       <= y_loc_d;
         pix_tick_q    <= pix_tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign video_on    = video_on_q;
   assign x_loc       = x_loc_q;
   assign y_loc       = y_loc_q;
   assign pix_tick    = pix_tick_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small raster configurations driven with random
// enable/reset, checked every cycle against a linear-pixel-position model.
module tb_vga_timing_gen;

   localparam int A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 4;
   localparam int A_VA = 6,  A_VF = 1, A_VS = 2, A_VB = 2;
   localparam int A_DIV = 3;
   localparam int B_HA = 10, B_HF = 1, B_HS = 2, B_HB = 3;
   localparam int B_VA = 4,  B_VF = 2, B_VS = 1, B_VB = 1;
   localparam int B_DIV = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;

   logic a_hs, a_vs, a_von, a_pt, a_ls, a_fs;
   logic [5:0] a_x, a_y;
   logic b_hs, b_vs, b_von, b_pt, b_ls, b_fs;
   logic [4:0] b_x, b_y;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .CLK_DIV(A_DIV), .HS_POL(1'b0), .VS_POL(1'b0), .CW(6)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable),
      .h_sync(a_hs), .v_sync(a_vs), .video_on(a_von),
      .x_loc(a_x), .y_loc(a_y), .pix_tick(a_pt),
      .line_start(a_ls), .frame_start(a_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .CLK_DIV(B_DIV), .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable),
      .h_sync(b_hs), .v_sync(b_vs), .video_on(b_von),
      .x_loc(b_x), .y_loc(b_y), .pix_tick(b_pt),
      .line_start(b_ls), .frame_start(b_fs)
   );

   int n_checks = 0;
   int n_pass = 0;

   int ha[2], hf[2], hs[2], ht[2], va[2], vf[2], vs[2], vt[2], dv[2];
   bit hp[2], vp[2];

   // model state: divider phase, linear pixel index within the frame
   int m_div[2], m_pos[2];
   bit m_first[2];
   bit e_hs[2], e_vs[2], e_von[2], e_pt[2], e_ls[2], e_fs[2];
   int e_x[2], e_y[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic decode(input int k);
      int h, v;
      h = m_pos[k] % ht[k];
      v = m_pos[k] / ht[k];
      e_hs[k]  = (h >= ha[k] + hf[k] && h < ha[k] + hf[k] + hs[k]) ? hp[k] : ~hp[k];
      e_vs[k]  = (v >= va[k] + vf[k] && v < va[k] + vf[k] + vs[k]) ? vp[k] : ~vp[k];
      e_von[k] = (h < ha[k]) && (v < va[k]);
      e_x[k]   = e_von[k] ? h : 0;
      e_y[k]   = e_von[k] ? v : 0;
   endtask

   task automatic model_step(input int k);
      bit t;
      if (reset) begin
         m_div[k] = 0; m_pos[k] = 0; m_first[k] = 1'b1;
         e_hs[k] = ~hp[k]; e_vs[k] = ~vp[k]; e_von[k] = 1'b0;
         e_x[k] = 0; e_y[k] = 0;
         e_pt[k] = 1'b0; e_ls[k] = 1'b0; e_fs[k] = 1'b0;
      end else if (!enable) begin
         e_pt[k] = 1'b0; e_ls[k] = 1'b0; e_fs[k] = 1'b0;
      end else begin
         t = (m_div[k] == dv[k] - 1);
         m_div[k] = (m_div[k] + 1) % dv[k];
         e_pt[k] = t; e_ls[k] = 1'b0; e_fs[k] = 1'b0;
         if (t) begin
            if (m_first[k]) m_first[k] = 1'b0;
            else begin
               m_pos[k] = (m_pos[k] + 1) % (ht[k] * vt[k]);
               e_ls[k] = (m_pos[k] % ht[k] == 0);
               e_fs[k] = (m_pos[k] == 0);
            end
            decode(k);
         end
      end
   endtask

   task automatic check_inst(input int k);
      logic [5:0] o;
      logic [31:0] ox, oy;
      string p;
      if (k == 0) begin
         o = {a_hs, a_vs, a_von, a_pt, a_ls, a_fs}; ox = 32'(a_x); oy = 32'(a_y); p = "a";
      end else begin
         o = {b_hs, b_vs, b_von, b_pt, b_ls, b_fs}; ox = 32'(b_x); oy = 32'(b_y); p = "b";
      end
      chk({p, ".h_sync"},      32'(o[5]), 32'(e_hs[k]));
      chk({p, ".v_sync"},      32'(o[4]), 32'(e_vs[k]));
      chk({p, ".video_on"},    32'(o[3]), 32'(e_von[k]));
      chk({p, ".pix_tick"},    32'(o[2]), 32'(e_pt[k]));
      chk({p, ".line_start"},  32'(o[1]), 32'(e_ls[k]));
      chk({p, ".frame_start"}, 32'(o[0]), 32'(e_fs[k]));
      chk({p, ".x_loc"},       ox, 32'(e_x[k]));
      chk({p, ".y_loc"},       oy, 32'(e_y[k]));
   endtask

   task automatic step();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_inst(0);
      check_inst(1);
   endtask

   initial begin
      int cnt;
      bit found;
      ha = '{A_HA, B_HA}; hf = '{A_HF, B_HF}; hs = '{A_HS, B_HS};
      va = '{A_VA, B_VA}; vf = '{A_VF, B_VF}; vs = '{A_VS, B_VS};
      ht = '{A_HA + A_HF + A_HS + A_HB, B_HA + B_HF + B_HS + B_HB};
      vt = '{A_VA + A_VF + A_VS + A_VB, B_VA + B_VF + B_VS + B_VB};
      dv = '{A_DIV, B_DIV};
      hp = '{1'b0, 1'b1}; vp = '{1'b0, 1'b1};

      reset = 1'b1; enable = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      repeat (1800) step();

      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 7) != 0);
         reset  = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 99) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 40)) step();
         end
         step();
      end

      // freeze mid-line while the active area is displayed
      reset = 1'b0; enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step();
         if (e_pt[0] && !m_first[0] && (m_pos[0] % ht[0] == 10) && (m_pos[0] / ht[0] < va[0]))
            found = 1'b1;
      end
      chk("find_h10", 32'(found), 32'd1);
      enable = 1'b0;
      repeat (37) step();
      chk("hold_x", 32'(a_x), 32'd10);
      chk("hold_strobe", 32'({a_pt, a_ls, a_fs}), 32'd0);
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (a_pt) found = 1'b1;
      end
      chk("resume_tick", 32'(found), 32'd1);
      chk("resume_x", 32'(a_x), 32'd11);

      // reset in the middle of the horizontal sync pulse
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step();
         if (e_pt[0] && !m_first[0] && (m_pos[0] % ht[0] == A_HA + A_HF + 1) && (m_pos[0] / ht[0] == 3))
            found = 1'b1;
      end
      chk("find_hsync", 32'(found), 32'd1);
      chk("in_hsync", 32'(a_hs), 32'd0);
      reset = 1'b1;
      step();
      chk("rst_hs", 32'(a_hs), 32'd1);
      chk("rst_von", 32'(a_von), 32'd0);
      reset = 1'b0;
      cnt = 0;
      repeat (825) begin
         step();
         if (a_fs) cnt++;
      end
      chk("no_early_fs", 32'(cnt), 32'd0);
      repeat (40) begin
         step();
         if (a_fs) cnt++;
      end
      chk("first_fs", 32'(cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
